// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the BCD stopwatch controller
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] C1_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0] C10_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] S1_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0] S10_MAX = 4'd5;
   localparam logic [6:0] SEG_0 = 7'b100_0000;
   localparam logic [6:0] SEG_1 = 7'b111_1001;
   localparam logic [6:0] SEG_2 = 7'b010_0100;
   localparam logic [6:0] SEG_3 = 7'b011_0000;
   localparam logic [6:0] SEG_4 = 7'b001_1001;
   localparam logic [6:0] SEG_5 = 7'b001_0010;
   localparam logic [6:0] SEG_6 = 7'b000_0010;
   localparam logic [6:0] SEG_7 = 7'b111_1000;
   localparam logic [6:0] SEG_8 = 7'b000_0000;
   localparam logic [6:0] SEG_9 = 7'b001_0000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic DP_ON  = 1'b0;
   localparam logic DP_OFF = 1'b1;
   localparam logic [1:0] DP_IDX = 2'd2;
endpackage

// File: rtl/decoder_7seg.sv
// decoder_7seg: BCD digit to active-low segments {g,f,e,d,c,b,a}, blank for non-BCD codes
module decoder_7seg
   import stopwatch_pkg::*;
(
   input  logic [DIGIT_W-1:0] bcd,
   output logic [6:0]         seg
);
   // map each BCD code onto its segment pattern
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one cascadable BCD counter stage counting 0..MAX with carry out
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               clr,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);
   assign carry = en & (q == MAX);

   // clear wins; otherwise advance on enable and wrap after MAX
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= (q == MAX) ? '0 : q + 1'b1;
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven SS.cc stopwatch with lap latch and multiplexed FND drive
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 1_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_start_stop,
   input  logic        btn_lap,
   input  logic        btn_clear,
   output logic [7:0]  seg_7,
   output logic [3:0]  com,
   output logic [15:0] time_bcd,
   output logic        running
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   state_t state, next_state;
   logic [2:0]         btn_d;
   logic [2:0]         rise;
   logic               cmd_ss, cmd_clr, cmd_lap;
   logic               capture, clear;
   logic               counting, tick;
   logic [TW-1:0]      tick_cnt;
   logic [SW-1:0]      scan_cnt;
   logic               scan_wrap;
   logic [1:0]         idx;
   logic [15:0]        latch;
   logic [15:0]        disp;
   logic [DIGIT_W-1:0] digit;
   logic [DIGIT_W-1:0] c1, c10, s1, s10;
   logic               c1_carry, c10_carry, s1_carry, carry_unused;
   logic [6:0]         seg;

   // one command per cycle: start_stop beats clear, clear beats lap
   assign rise    = {btn_start_stop, btn_lap, btn_clear} & ~btn_d;
   assign cmd_ss  = rise[2];
   assign cmd_clr = rise[0] & ~rise[2];
   assign cmd_lap = rise[1] & ~rise[2] & ~rise[0];

   assign counting = (state == RUN) || (state == LAP);
   assign tick     = counting && (tick_cnt == TICK_LAST);

   // registered button copies for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) btn_d <= '0;
      else btn_d <= {btn_start_stop, btn_lap, btn_clear};
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= next_state;
   end

   // command decode per state; lap from RUN captures, clear from PAUSE zeroes
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      clear      = 1'b0;
      case (state)
         IDLE:  if (cmd_ss) next_state = RUN;
         RUN: begin
            if (cmd_ss) next_state = PAUSE;
            else if (cmd_lap) begin
               next_state = LAP;
               capture    = 1'b1;
            end
         end
         LAP: begin
            if (cmd_ss) next_state = PAUSE;
            else if (cmd_lap) next_state = RUN;
         end
         PAUSE: begin
            if (cmd_ss) next_state = RUN;
            else if (cmd_clr) begin
               next_state = IDLE;
               clear      = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // prescaler: runs while counting, holds in PAUSE so partial ticks survive
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick_cnt <= '0;
      else if (state == IDLE || clear) tick_cnt <= '0;
      else if (counting) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   bcd_digit #(.MAX(C1_MAX)) u_c1 (
      .clk(clk), .reset_n(reset_n), .en(tick), .clr(clear), .q(c1), .carry(c1_carry)
   );
   bcd_digit #(.MAX(C10_MAX)) u_c10 (
      .clk(clk), .reset_n(reset_n), .en(c1_carry), .clr(clear), .q(c10), .carry(c10_carry)
   );
   bcd_digit #(.MAX(S1_MAX)) u_s1 (
      .clk(clk), .reset_n(reset_n), .en(c10_carry), .clr(clear), .q(s1), .carry(s1_carry)
   );
   bcd_digit #(.MAX(S10_MAX)) u_s10 (
      .clk(clk), .reset_n(reset_n), .en(s1_carry), .clr(clear), .q(s10), .carry(carry_unused)
   );

   assign time_bcd = {s10, s1, c10, c1};

   // lap latch holds the pre-tick count seen at the lap edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) latch <= '0;
      else if (clear) latch <= '0;
      else if (capture) latch <= time_bcd;
   end

   // running mirrors the current state, so it follows a state change by one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) running <= 1'b0;
      else running <= counting;
   end

   assign scan_wrap = (scan_cnt == SCAN_LAST);

   // digit scan: com rotates together with idx so both always name the same digit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         com      <= 4'b1110;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
         if (scan_wrap) begin
            idx <= idx + 1'b1;
            com <= {com[2:0], com[3]};
         end
      end
   end

   assign disp  = (state == LAP) ? latch : time_bcd;
   assign digit = disp[{idx, 2'b00} +: DIGIT_W];

   decoder_7seg u_dec (.bcd(digit), .seg(seg));

   assign seg_7 = {(idx == DP_IDX) ? DP_ON : DP_OFF, seg};
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench with a centisecond-level reference model
module tb_stopwatch_ctrl;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        btn_start_stop = 1'b0;
   logic        btn_lap = 1'b0;
   logic        btn_clear = 1'b0;
   logic [7:0]  seg_7;
   logic [3:0]  com;
   logic [15:0] time_bcd;
   logic        running;

   stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset_n(reset_n), .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
      .btn_clear(btn_clear), .seg_7(seg_7), .com(com), .time_bcd(time_bcd), .running(running)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] t;
      logic        r;
      logic [3:0]  c;
      logic [7:0]  s;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int n_vec = 0;
   int n_bad = 0;
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // reference model: mode 0 idle, 1 run, 2 pause, 3 lap; time kept in centiseconds
   int m_mode, m_cs, m_latch, m_pre, m_scan, m_idx;
   logic [2:0] m_prev;
   logic m_run;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic exp_t exp_now();
      exp_t e;
      int d;
      d = (m_mode == 3) ? m_latch : m_cs;
      for (int k = 0; k < m_idx; k++) d = d / 10;
      e.t = to_bcd(m_cs);
      e.r = m_run;
      e.c = 4'(~(4'b0001 << m_idx));
      e.s = {m_idx != 2, seg_tab[d % 10]};
      return e;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cs = 0; m_latch = 0; m_pre = 0; m_scan = 0; m_idx = 0;
      m_prev = 3'b000; m_run = 1'b0;
   endtask

   task automatic model_step(input bit ss, input bit lap, input bit clr);
      bit r_ss, r_lap, r_clr, counting, tick;
      int cmd;
      r_ss  = ss && !m_prev[2];
      r_lap = lap && !m_prev[1];
      r_clr = clr && !m_prev[0];
      cmd = r_ss ? 1 : r_clr ? 2 : r_lap ? 3 : 0;
      counting = (m_mode == 1) || (m_mode == 3);
      tick = counting && (m_pre == TICK_DIV - 1);
      m_run = counting;
      if (m_mode == 1 && cmd == 3) m_latch = m_cs;
      if (tick) m_cs = (m_cs + 1) % 6000;
      if (m_mode == 0) m_pre = 0;
      else if (counting) m_pre = tick ? 0 : m_pre + 1;
      case (m_mode)
         0: if (cmd == 1) m_mode = 1;
         1: if (cmd == 1) m_mode = 2; else if (cmd == 3) m_mode = 3;
         3: if (cmd == 1) m_mode = 2; else if (cmd == 3) m_mode = 1;
         default: if (cmd == 1) m_mode = 1;
                  else if (cmd == 2) begin m_mode = 0; m_cs = 0; m_latch = 0; m_pre = 0; end
      endcase
      if (m_scan == SCAN_DIV - 1) begin
         m_scan = 0;
         m_idx = (m_idx + 1) % 4;
      end else m_scan++;
      m_prev = {ss, lap, clr};
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // called at posedge+2: drive, predict the post-edge outputs, queue them, cross the edge
   task automatic step(input bit ss, input bit lap, input bit clr);
      btn_start_stop = ss; btn_lap = lap; btn_clear = clr;
      model_step(ss, lap, clr);
      sb.push_back(exp_now());
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst time_bcd", time_bcd, 32'h0);
      check("rst running", running, 32'h0);
      check("rst com", com, 32'he);
      check("rst seg_7", seg_7, 32'hc0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      model_reset();
   endtask

   // monitor: one posedge+1 sample per queued prediction
   initial forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         if ({time_bcd, running, com, seg_7} !== mon_e) begin
            n_bad++;
            $display("FAIL scoreboard @%0t: got time=%h run=%b com=%b seg=%b, expected time=%h run=%b com=%b seg=%b",
                     $time, time_bcd, running, com, seg_7, mon_e.t, mon_e.r, mon_e.c, mon_e.s);
         end
      end
   end

   logic [3:0] com_seq [8] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
   int n;
   bit b_ss, b_lap, b_clr;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check("hold time_bcd", time_bcd, 32'h0);
      check("hold com", com, 32'he);
      check("hold seg_7", seg_7, 32'hc0);
      reset_n = 1'b1;
      // first increments after start
      step(1, 0, 0);
      repeat (44) step(0, 0, 0);
      check("start 11 ticks", time_bcd, 32'h0011);
      check("start running", running, 32'h1);
      // held start_stop pauses once; resume finishes the partial tick
      do_reset();
      step(1, 0, 0);
      repeat (24) step(0, 0, 0);
      check("six ticks", time_bcd, 32'h0006);
      repeat (20) step(1, 0, 0);
      check("paused hold", time_bcd, 32'h0006);
      check("paused running", running, 32'h0);
      repeat (3) step(0, 0, 0);
      check("paused still", time_bcd, 32'h0006);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("resume partial pre", time_bcd, 32'h0006);
      step(0, 0, 0);
      check("resume partial tick", time_bcd, 32'h0007);
      // lap freezes the display at 00.12
      n = 0;
      while (m_cs != 12 && n < 200) begin step(0, 0, 0); n++; end
      check("reach 0012", time_bcd, 32'h0012);
      step(0, 1, 0);
      repeat (16) begin
         step(0, 0, 0);
         if (com == 4'b1110) check("lap c1 shown", seg_7, 32'ha4);
         if (com == 4'b1101) check("lap c10 shown", seg_7, 32'hf9);
         if (com == 4'b1011) check("lap s1 dp", seg_7, 32'h40);
      end
      check("lap live advances", time_bcd, 32'h0016);
      step(0, 1, 0);
      repeat (8) step(0, 0, 0);
      check("lap back running", running, 32'h1);
      // wrap from 59.99
      n = 0;
      while (m_cs != 5999 && n < 30000) begin step(0, 0, 0); n++; end
      check("reach 5999", time_bcd, 32'h5999);
      n = 0;
      while (m_cs == 5999 && n < 10) begin step(0, 0, 0); n++; end
      check("wrap to 0000", time_bcd, 32'h0000);
      check("wrap running", running, 32'h1);
      // start_stop beats clear in PAUSE; clear later returns to IDLE
      repeat (30) step(0, 0, 0);
      step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      step(1, 0, 1);
      step(0, 0, 0);
      check("ss over clear", running, 32'h1);
      step(1, 0, 0);
      repeat (2) step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      check("clear time", time_bcd, 32'h0);
      check("clear idle", running, 32'h0);
      // async reset mid-run in LAP, then the scan rotation from reset
      step(1, 0, 0);
      repeat (10) step(0, 0, 0);
      step(0, 1, 0);
      repeat (5) step(0, 0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0);
         check("scan com", com, 32'(com_seq[i]));
         check("scan dp", seg_7[7], (com_seq[i] == 4'b1011) ? 32'h0 : 32'h1);
      end
      // randomized button activity
      b_ss = 0; b_lap = 0; b_clr = 0;
      repeat (4000) begin
         if ($urandom_range(0, 5) == 0) b_ss = ~b_ss;
         if ($urandom_range(0, 5) == 0) b_lap = ~b_lap;
         if ($urandom_range(0, 7) == 0) b_clr = ~b_clr;
         step(b_ss, b_lap, b_clr);
      end
      step(0, 0, 0);
      check("scoreboard drained", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
